// File: rtl/vsync_cfg_seq.sv
// vsync_cfg_seq: APB-master sequencer that disables, programs and re-arms the VSYNC generator ctrl words 0..5
// Ports: i_clk/i_rst (sync, active-high) clock and reset
//        i_start/i_abort host request and abort; i_mode/i_dly/i_start_val/i_exp_time/i_gpio_mux config values
//        i_pps PPS level (i_clk domain)
//        o_apb_* / i_apb_ready / i_apb_serr APB master port toward the generator
//        o_busy/o_done/o_err/o_err_code host status (code 1 slave error, 2 APB timeout, 3 PPS timeout)
module vsync_cfg_seq #(
    parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
    parameter logic        ARM_ON_PPS  = 1'b1,
    parameter logic [31:0] ARM_DLY_CYC = 32'd50_000_000,
    parameter logic [15:0] APB_TO_CYC  = 16'd1024,
    parameter logic [31:0] PPS_TO_CYC  = 32'd300_000_000
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_start,
    input  logic        i_abort,
    input  logic [3:0]  i_mode,
    input  logic [31:0] i_dly,
    input  logic        i_start_val,
    input  logic [31:0] i_exp_time,
    input  logic [7:0]  i_gpio_mux,
    input  logic        i_pps,
    output logic        o_apb_sel,
    output logic        o_apb_enable,
    output logic        o_apb_write,
    output logic [31:0] o_apb_addr,
    output logic [31:0] o_apb_wdata,
    input  logic        i_apb_ready,
    input  logic        i_apb_serr,
    output logic        o_busy,
    output logic        o_done,
    output logic        o_err,
    output logic [1:0]  o_err_code
);
    typedef enum logic [2:0] {IDLE, SETUP, ACCESS, NEXT, WAIT_PPS, ARM_DLY, DONE, ERR} state_t;
    state_t      r_state, w_state_nx;
    logic [2:0]  r_idx;
    logic [3:0]  r_mode;
    logic [31:0] r_dly, r_exp, r_cnt;
    logic        r_sv, r_pps_q, r_abort, r_err;
    logic [7:0]  r_mux;
    logic [15:0] r_to;
    logic [1:0]  r_err_code, w_code;
    logic        w_accept, w_abort, w_edge, w_apb_to, w_pps_to, w_dly_hit, w_sel;
    logic [2:0]  w_word;
    logic [31:0] w_wdata;
    assign w_accept  = (r_state == IDLE) && i_start && !i_abort;
    // an abort seen during a transfer is remembered until the transfer ends
    assign w_abort   = i_abort | r_abort;
    assign w_edge    = i_pps & ~r_pps_q;
    assign w_apb_to  = ({1'b0, r_to} + 17'd1) >= {1'b0, APB_TO_CYC};
    assign w_pps_to  = ({1'b0, r_cnt} + 33'd1) >= {1'b0, PPS_TO_CYC};
    // the edge cycle itself counts as the first delay cycle, so SETUP lands ARM_DLY_CYC cycles after the edge
    assign w_dly_hit = ({1'b0, r_cnt} + 33'd1) >= {1'b0, ARM_DLY_CYC};
    // index 6 is the final arm write, which targets ctrl word 0 again
    assign w_word    = (r_idx == 3'd6) ? 3'd0 : r_idx;
    assign w_wdata   = (r_idx == 3'd1) ? {28'd0, r_mode} :
                       (r_idx == 3'd2) ? r_dly :
                       (r_idx == 3'd3) ? {31'd0, r_sv} :
                       (r_idx == 3'd4) ? r_exp :
                       (r_idx == 3'd5) ? {24'd0, r_mux} :
                       (r_idx == 3'd6) ? 32'd1 : 32'd0;
    assign w_sel        = (r_state == SETUP) || (r_state == ACCESS);
    assign o_apb_sel    = w_sel;
    assign o_apb_enable = (r_state == ACCESS);
    assign o_apb_write  = w_sel;
    assign o_apb_addr   = w_sel ? BASE_ADDR + {27'd0, w_word, 2'b00} : 32'd0;
    assign o_apb_wdata  = w_sel ? w_wdata : 32'd0;
    assign o_busy       = !(r_state == IDLE || r_state == DONE || r_state == ERR);
    assign o_done       = (r_state == DONE);
    assign o_err        = r_err;
    assign o_err_code   = r_err_code;
    always_ff @(posedge i_clk) begin
        if (i_rst) r_state <= IDLE;
        else r_state <= w_state_nx;
    end
    always_comb begin
        w_state_nx = r_state;
        w_code     = 2'd0;
        case (r_state)
            IDLE:     w_state_nx = w_accept ? SETUP : IDLE;
            SETUP:    w_state_nx = ACCESS;
            ACCESS: begin
                if (i_apb_ready) begin
                    if (i_apb_serr) begin
                        w_state_nx = ERR;
                        w_code     = 2'd1;
                    end else if (w_abort) w_state_nx = IDLE;
                    else if (r_idx == 3'd6) w_state_nx = DONE;
                    else if (r_idx == 3'd5 && ARM_ON_PPS) w_state_nx = WAIT_PPS;
                    else w_state_nx = NEXT;
                end else if (w_apb_to) begin
                    w_state_nx = ERR;
                    w_code     = 2'd2;
                end
            end
            NEXT:     w_state_nx = w_abort ? IDLE : SETUP;
            WAIT_PPS: begin
                if (w_abort) w_state_nx = IDLE;
                else if (w_edge) w_state_nx = ARM_DLY;
                else if (w_pps_to) begin
                    w_state_nx = ERR;
                    w_code     = 2'd3;
                end
            end
            ARM_DLY:  w_state_nx = w_abort ? IDLE : w_dly_hit ? SETUP : ARM_DLY;
            default:  w_state_nx = IDLE;
        endcase
    end
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_idx      <= 3'd0;
            r_mode     <= 4'd0;
            r_dly      <= 32'd0;
            r_exp      <= 32'd0;
            r_sv       <= 1'b0;
            r_mux      <= 8'd0;
            r_pps_q    <= 1'b0;
            r_abort    <= 1'b0;
            r_to       <= 16'd0;
            r_cnt      <= 32'd0;
            r_err      <= 1'b0;
            r_err_code <= 2'd0;
        end else begin
            r_pps_q <= i_pps;
            r_abort <= (r_state == IDLE) ? 1'b0 : (r_abort | i_abort);
            r_to    <= (r_state == ACCESS && !i_apb_ready) ? r_to + 16'd1 : 16'd0;
            r_cnt   <= (r_state == WAIT_PPS) ? (w_edge ? 32'd1 : r_cnt + 32'd1) :
                       (r_state == ARM_DLY) ? r_cnt + 32'd1 : 32'd0;
            if (r_state == ACCESS && i_apb_ready && !i_apb_serr) r_idx <= r_idx + 3'd1;
            if (w_accept) begin
                r_mode     <= i_mode;
                r_dly      <= i_dly;
                r_sv       <= i_start_val;
                r_exp      <= i_exp_time;
                r_mux      <= i_gpio_mux;
                r_idx      <= 3'd0;
                r_err      <= 1'b0;
                r_err_code <= 2'd0;
            end
            if (w_state_nx == ERR) begin
                r_err      <= 1'b1;
                r_err_code <= w_code;
            end
        end
    end
endmodule

// File: tb/tb_vsync_cfg_seq.sv
// tb_vsync_cfg_seq: scoreboard bench for vsync_cfg_seq (immediate arm, PPS arm, PPS timeout instances)
module tb_vsync_cfg_seq;
    localparam logic [31:0] BASE1 = 32'h4000_0000;
    logic        clk = 1'b0, rst = 1'b1;
    logic [2:0]  start = 3'd0;
    logic        abort = 1'b0, sv = 1'b0, pps = 1'b0, ready = 1'b0, serr = 1'b0;
    logic [3:0]  mode = 4'd0;
    logic [31:0] dly = 32'd0, expt = 32'd0;
    logic [7:0]  mux = 8'd0;
    logic [2:0]  sel, en, wr, busy, done, err;
    logic [1:0]  code [3];
    logic [31:0] addr [3], wdata [3];
    logic [63:0] q[$];
    int n_cmp = 0, n_bad = 0, a = 0, ws_idx = -1, ws_n = 0, serr_idx = -1, nx = 0, wcnt = 0, acc_cnt = 0;
    bit no_ready = 1'b0;
    always #5 clk = ~clk;
    for (genvar g = 0; g < 3; g++) begin : gen_dut
        vsync_cfg_seq #(
            .BASE_ADDR(g == 1 ? BASE1 : 32'h0), .ARM_ON_PPS(g != 0), .ARM_DLY_CYC(32'd20),
            .APB_TO_CYC(16'd8), .PPS_TO_CYC(g == 2 ? 32'd50 : 32'd1000)
        ) u_dut (
            .i_clk(clk), .i_rst(rst), .i_start(start[g]), .i_abort(abort), .i_mode(mode), .i_dly(dly),
            .i_start_val(sv), .i_exp_time(expt), .i_gpio_mux(mux), .i_pps(pps),
            .o_apb_sel(sel[g]), .o_apb_enable(en[g]), .o_apb_write(wr[g]), .o_apb_addr(addr[g]),
            .o_apb_wdata(wdata[g]), .i_apb_ready(ready), .i_apb_serr(serr), .o_busy(busy[g]),
            .o_done(done[g]), .o_err(err[g]), .o_err_code(code[g])
        );
    end
    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask
    // APB slave model + scoreboard: each ACCESS cycle is checked against the head of the expected queue
    always @(negedge clk) begin
        ready = 1'b0;
        serr  = 1'b0;
        if (sel[a] && en[a]) begin
            acc_cnt++;
            chk("pwrite", {31'd0, wr[a]}, 32'd1);
            if (q.size() == 0) begin
                chk("spurious_write", 32'(q.size()), 32'd1);
                ready = 1'b1;
                nx++;
            end else begin
                chk("paddr", addr[a], q[0][63:32]);
                chk("pwdata", wdata[a], q[0][31:0]);
                if (!no_ready && !(nx == ws_idx && wcnt < ws_n)) begin
                    ready = 1'b1;
                    serr  = (nx == serr_idx);
                    void'(q.pop_front());
                    nx++;
                    wcnt = 0;
                end else wcnt++;
            end
        end
    end
    task automatic cfg(input int d, input int wi, input int wn, input int si, input bit nr);
        a = d; ws_idx = wi; ws_n = wn; serr_idx = si; no_ready = nr;
        nx = 0; wcnt = 0; acc_cnt = 0;
        q.delete();
    endtask
    task automatic push(input int n);
        logic [31:0] d [7];
        d = '{32'd0, {28'd0, mode}, dly, {31'd0, sv}, expt, {24'd0, mux}, 32'd1};
        for (int i = 0; i < n; i++) q.push_back({(a == 1 ? BASE1 : 32'h0) + 32'(4 * (i % 6)), d[i]});
    endtask
    // pulse start with the given config; inputs are scrambled afterwards so only the shadow copy is valid
    task automatic kick(input logic [3:0] m, input logic [31:0] dl, input logic s, input logic [31:0] e,
                        input logic [7:0] x, input int n);
        @(negedge clk);
        mode = m; dly = dl; sv = s; expt = e; mux = x;
        push(n);
        start[a] = 1'b1;
        @(negedge clk);
        start[a] = 1'b0;
        mode = ~m; dly = ~dl; sv = ~s; expt = ~e; mux = ~x;
    endtask
    task automatic wait_idle(input int max, output int cyc);
        cyc = -1;
        for (int i = 0; i < max; i++) begin
            if (!busy[a] || done[a]) begin
                cyc = i;
                break;
            end
            @(negedge clk);
        end
        if (cyc < 0) chk("idle_bound", 32'd0, 32'd1);
    endtask
    initial begin
        int cyc, k;
        repeat (3) @(negedge clk);
        for (int d = 0; d < 3; d++) begin
            chk("rst_ctl", {26'd0, sel[d], en[d], wr[d], busy[d], done[d], err[d]}, 32'd0);
            chk("rst_code", {30'd0, code[d]}, 32'd0);
            chk("rst_addr", addr[d], 32'd0);
            chk("rst_wdata", wdata[d], 32'd0);
        end
        rst = 1'b0;
        cfg(0, -1, 0, -1, 1'b0);
        kick(4'd2, 32'd1000, 1'b1, 32'd500, 8'h03, 7);
        wait_idle(60, cyc);
        chk("t1_cycles", 32'(cyc), 32'd20);
        chk("t1_done", {31'd0, done[0]}, 32'd1);
        chk("t1_busy", {31'd0, busy[0]}, 32'd0);
        chk("t1_err", {31'd0, err[0]}, 32'd0);
        @(negedge clk);
        chk("t1_done_pulse", {31'd0, done[0]}, 32'd0);
        chk("t1_access", 32'(acc_cnt), 32'd7);
        chk("t1_left", 32'(q.size()), 32'd0);
        cfg(0, 2, 3, -1, 1'b0);
        kick(4'hF, 32'hDEAD_BEEF, 1'b0, 32'h1234_5678, 8'hA5, 7);
        repeat (4) @(negedge clk);
        start[0] = 1'b1;
        @(negedge clk);
        start[0] = 1'b0;
        wait_idle(60, cyc);
        chk("t2_cycles", 32'(cyc), 32'd18);
        chk("t2_done", {31'd0, done[0]}, 32'd1);
        chk("t2_access", 32'(acc_cnt), 32'd10);
        chk("t2_left", 32'(q.size()), 32'd0);
        cfg(0, -1, 0, 1, 1'b0);
        kick(4'd5, 32'd7, 1'b1, 32'd9, 8'h11, 2);
        wait_idle(60, cyc);
        chk("t3_cycles", 32'(cyc), 32'd5);
        chk("t3_err", {31'd0, err[0]}, 32'd1);
        chk("t3_code", {30'd0, code[0]}, 32'd1);
        chk("t3_done", {31'd0, done[0]}, 32'd0);
        repeat (10) @(negedge clk);
        chk("t3_writes", 32'(nx), 32'd2);
        cfg(0, -1, 0, -1, 1'b0);
        kick(4'd1, 32'd2, 1'b0, 32'd3, 8'h04, 7);
        chk("t3_err_clr", {31'd0, err[0]}, 32'd0);
        chk("t3_code_clr", {30'd0, code[0]}, 32'd0);
        wait_idle(60, cyc);
        chk("t3_redo_done", {31'd0, done[0]}, 32'd1);
        cfg(0, -1, 0, -1, 1'b1);
        kick(4'd3, 32'd4, 1'b1, 32'd5, 8'h06, 1);
        wait_idle(60, cyc);
        chk("t4_cycles", 32'(cyc), 32'd9);
        chk("t4_access", 32'(acc_cnt), 32'd8);
        chk("t4_sel", {31'd0, sel[0]}, 32'd0);
        chk("t4_err", {31'd0, err[0]}, 32'd1);
        chk("t4_code", {30'd0, code[0]}, 32'd2);
        cfg(1, -1, 0, -1, 1'b0);
        kick(4'd6, 32'd77, 1'b1, 32'd88, 8'hC3, 7);
        for (int i = 0; i < 100 && q.size() != 1; i++) @(negedge clk);
        repeat (100) @(negedge clk);
        pps = 1'b1;
        for (k = 1; k <= 200; k++) begin
            @(negedge clk);
            if (k == 5) pps = 1'b0;
            if (k == 10) pps = 1'b1;
            if (sel[1] && !en[1]) break;
        end
        chk("t5_arm_delay", 32'(k), 32'd20);
        wait_idle(100, cyc);
        chk("t5_done", {31'd0, done[1]}, 32'd1);
        chk("t5_err", {31'd0, err[1]}, 32'd0);
        chk("t5_left", 32'(q.size()), 32'd0);
        pps = 1'b0;
        cfg(2, -1, 0, -1, 1'b0);
        kick(4'd9, 32'd1, 1'b0, 32'd2, 8'h3C, 7);
        wait_idle(200, cyc);
        chk("t5b_cycles", 32'(cyc), 32'd67);
        chk("t5b_err", {31'd0, err[2]}, 32'd1);
        chk("t5b_code", {30'd0, code[2]}, 32'd3);
        chk("t5b_done", {31'd0, done[2]}, 32'd0);
        chk("t5b_writes", 32'(nx), 32'd6);
        cfg(0, 3, 3, -1, 1'b0);
        kick(4'd7, 32'd11, 1'b1, 32'd12, 8'h5A, 4);
        for (int i = 0; i < 60 && !(sel[0] && en[0] && addr[0] == 32'hC); i++) @(negedge clk);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        wait_idle(60, cyc);
        chk("t6_done", {31'd0, done[0]}, 32'd0);
        chk("t6_busy", {31'd0, busy[0]}, 32'd0);
        chk("t6_err", {31'd0, err[0]}, 32'd0);
        repeat (8) @(negedge clk);
        chk("t6_writes", 32'(nx), 32'd4);
        chk("t6_left", 32'(q.size()), 32'd0);
        cfg(0, -1, 0, -1, 1'b0);
        @(negedge clk);
        start[0] = 1'b1;
        abort = 1'b1;
        @(negedge clk);
        start[0] = 1'b0;
        abort = 1'b0;
        chk("t6b_busy", {31'd0, busy[0]}, 32'd0);
        repeat (5) @(negedge clk);
        chk("t6b_writes", 32'(nx), 32'd0);
        cfg(0, -1, 0, -1, 1'b1);
        kick(4'd2, 32'd3, 1'b0, 32'd4, 8'h05, 1);
        repeat (2) @(negedge clk);
        chk("t7_in_access", {30'd0, sel[0], en[0]}, 32'd3);
        rst = 1'b1;
        @(negedge clk);
        chk("t7_bus_drop", {29'd0, sel[0], en[0], busy[0]}, 32'd0);
        rst = 1'b0;
        cfg(0, -1, 0, -1, 1'b0);
        @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/vsync_cfg_seq.md
Name: vsync_cfg_seq

Overview:
APB-master sequencer that programs and arms the camera VSYNC generator's register block (ctrl words 0..5) from a single software/host request.
- Programs the generator safely: disable, program mode/delay/start level/exposure/GPIO mux, then re-enable.
- Optionally times the re-enable to land mid-second after a PPS edge, so the generator starts on the next PPS.
- Sits between the host control plane and the generator's APB slave port; both run on i_clk.

Parameters:
BASE_ADDR, 32'h0000_0000, APB byte address of generator ctrl word 0; word n is at BASE_ADDR + 4*n.
ARM_ON_PPS, 1, 1 = wait for a PPS rising edge plus ARM_DLY_CYC before writing enable; 0 = write enable immediately.
ARM_DLY_CYC, 32'd50_000_000, cycles after the PPS edge before the enable write (width 32).
APB_TO_CYC, 16'd1024, maximum ACCESS-phase cycles before an APB timeout.
PPS_TO_CYC, 32'd300_000_000, maximum cycles waiting for a PPS edge.

Ports:
i_clk  in  1  clock (also the APB clock of the target)
i_rst  in  1  reset
i_start  in  1  1-cycle request; accepted only in IDLE
i_abort  in  1  abort request
i_mode  in  4  value for ctrl word 1
i_dly  in  32  value for ctrl word 2
i_start_val  in  1  value for ctrl word 3 bit 0
i_exp_time  in  32  value for ctrl word 4
i_gpio_mux  in  8  value for ctrl word 5 bits 7:0
i_pps  in  1  PPS level, synchronous to i_clk
o_apb_sel  out  1  APB PSEL
o_apb_enable  out  1  APB PENABLE
o_apb_write  out  1  APB PWRITE
o_apb_addr  out  32  APB PADDR
o_apb_wdata  out  32  APB PWDATA
i_apb_ready  in  1  APB PREADY
i_apb_serr  in  1  APB PSLVERR, sampled with ready
o_busy  out  1  high from accepted start until return to IDLE
o_done  out  1  1-cycle pulse on successful arm
o_err  out  1  sticky error flag, cleared on next accepted start
o_err_code  out  2  error code: 1 = slave error, 2 = APB timeout, 3 = PPS timeout

Behaviour:
Reset: i_rst is synchronous, active-high, on clock i_clk. All outputs reset to 0, state to IDLE, the i_pps edge-detect register to 0, and all counters to 0.

Start:
- i_start in IDLE captures all config inputs into shadow registers, clears o_err/o_err_code, sets o_busy, and sets write index = 0.
- i_start outside IDLE is ignored.

States: IDLE, SETUP, ACCESS, NEXT, WAIT_PPS, ARM_DLY, DONE, ERR.

Write list, in order; upper bits of each word are 0:
- idx0: 0 (disable)
- idx1: mode
- idx2: dly
- idx3: start_val
- idx4: exp_time
- idx5: gpio_mux
- then the arm write, idx0: 32'h1

APB transfer:
- SETUP (1 cycle): sel=1, enable=0, write=1, addr = BASE_ADDR + 4*idx, wdata valid.
- ACCESS: enable=1; addr/wdata/write held stable until i_apb_ready=1.
- Cycle after ready: sel=0, enable=0.
- If i_apb_serr=1 with ready: go to ERR, code 1.
- A new SETUP never directly follows ACCESS; the NEXT state always intervenes, giving at least 1 idle cycle between transfers.

APB timeout: counter increments each ACCESS cycle without ready. On reaching APB_TO_CYC, drop sel/enable and go to ERR, code 2. The counter resets at each SETUP.

After idx5:
- ARM_ON_PPS=0: issue the arm write immediately.
- ARM_ON_PPS=1: enter WAIT_PPS. Rising edge = i_pps & ~pps_q. On the edge, go to ARM_DLY and count ARM_DLY_CYC cycles, then issue the arm write.
- If PPS_TO_CYC cycles elapse in WAIT_PPS: go to ERR, code 3.
- An edge in ARM_DLY is ignored.

Completion:
- DONE: o_done=1 for 1 cycle, then IDLE; o_busy drops in the same cycle o_done pulses.
- ERR: o_err=1 (sticky), o_busy=0 next cycle, return to IDLE.

Abort:
- In SETUP/ACCESS, the current transfer completes (or times out) first; then return to IDLE with no o_done and no arm write.
- In WAIT_PPS/ARM_DLY/NEXT, return to IDLE next cycle.
- Abort and start in the same IDLE cycle: abort wins, start is ignored.
- Abort does not set o_err, except that a timeout occurring while the abort is pending still sets o_err with code 2.

Reset mid-transfer: the bus is dropped immediately (sel=enable=0 next cycle); no completion is required.

Test Plan:
1. ARM_ON_PPS=0, ready tied high, start with mode=2, dly=1000, exp=500, mux=8'h03 → 7 writes to addr 0,4,8,C,10,14,0 with data 0,2,1000,start_val,500,3,1; each transfer is SETUP+ACCESS+1 idle cycle; o_done pulses 1 cycle after the last ACCESS; o_busy spans start to done.
2. Slave inserts 3 wait states on the idx2 write → addr/wdata held stable for all 4 ACCESS cycles; sequence continues normally.
3. i_apb_serr=1 on the idx1 write → no further writes, o_err=1, o_err_code=1, no o_done; the next start clears o_err.
4. Ready never asserted, APB_TO_CYC=8 → sel drops after 8 ACCESS cycles, o_err_code=2.
5. ARM_ON_PPS=1, ARM_DLY_CYC=20, PPS edge 100 cycles after idx5 completes → arm write SETUP occurs exactly 20 cycles after the edge is detected. Separately, with no PPS and PPS_TO_CYC=50 → o_err_code=3.
6. Abort asserted during idx3 ACCESS → idx3 completes, no idx4/idx5/arm writes, o_busy=0, o_err=0. Start and abort in the same IDLE cycle → no transfer.
